act_buffer_ctrl: RTL and testbench

Ping/pong sequencer for the double-buffered activation buffer. It tracks fill and drain ownership of both banks and gates host writes so that a full bank is never overwritten. It steers `bank_sel_wr` and `bank_sel_rd`, and streams `k_idx` over a committed tile. It produces `a_valid` aligned to the buffer's 2-cycle read path, including the extra read-enable cycle the gated buffer clock needs to capture the last element.

---
 rtl/act_buffer_ctrl_if.sv | 36 +++
 rtl/act_buffer_ctrl.sv | 152 +++++++++++++++
 tb/tb_act_buffer_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_buffer_ctrl_if.sv
// Host, array and buffer-side signals of the activation buffer ping/pong sequencer.
// The master side drives requests; the slave side (the controller) drives status and buffer controls.
interface act_buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_waddr;
  logic                  host_commit;
  logic [ADDR_WIDTH:0]   k_len;
  logic                  host_wr_ready;
  logic                  wr_overflow;
  logic                  commit_err;
  logic                  rd_req;
  logic                  rd_busy;
  logic                  a_valid;
  logic                  tile_done;
  logic [1:0]            bank_full;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic                  bank_sel_wr;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] k_idx;
  logic                  bank_sel_rd;

  modport master (
    output host_we, host_waddr, host_commit, k_len, rd_req,
    input  host_wr_ready, wr_overflow, commit_err, rd_busy, a_valid, tile_done,
           bank_full, buf_we, buf_waddr, bank_sel_wr, buf_rd_en, k_idx, bank_sel_rd
  );

  modport slave (
    input  host_we, host_waddr, host_commit, k_len, rd_req,
    output host_wr_ready, wr_overflow, commit_err, rd_busy, a_valid, tile_done,
           bank_full, buf_we, buf_waddr, bank_sel_wr, buf_rd_en, k_idx, bank_sel_rd
  );
endinterface

// File: rtl/act_buffer_ctrl.sv
// Ping/pong sequencer for the double-buffered activation buffer: bank ownership,
// host write gating, and tile streaming with a_valid aligned to the 2-cycle read path.
module act_buffer_ctrl #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  act_buffer_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] K_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] K_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } rd_state_t;

  rd_state_t             state_r;
  rd_state_t             state_s;
  logic [1:0]            full_r;
  logic [1:0]            full_s;
  logic [ADDR_WIDTH:0]   len0_r;
  logic [ADDR_WIDTH:0]   len1_r;
  logic [ADDR_WIDTH:0]   len_rd_s;
  logic                  wr_bank_r;
  logic                  rd_bank_r;
  logic [ADDR_WIDTH-1:0] k_idx_r;
  logic [ADDR_WIDTH-1:0] k_idx_s;
  logic [1:0]            av_pipe_r;
  logic                  buf_rd_en_r;
  logic                  rd_busy_r;
  logic                  tile_done_r;
  logic                  wr_overflow_r;
  logic                  commit_err_r;
  logic                  klen_ok_s;
  logic                  commit_ok_s;
  logic                  release_s;
  logic                  last_elem_s;

  assign len_rd_s    = rd_bank_r ? len1_r : len0_r;
  assign klen_ok_s   = (bus.k_len != LEN_ZERO) && (bus.k_len <= DEPTH);
  assign commit_ok_s = bus.host_commit & ~full_r[wr_bank_r] & klen_ok_s;
  assign last_elem_s = ({1'b0, k_idx_r} == (len_rd_s - LEN_ONE));

  // A commit only ever sets an empty bank and a release only clears a full one,
  // so both can be applied in the same cycle without colliding.
  assign full_s[0] = (full_r[0] & ~(release_s & ~rd_bank_r)) | (commit_ok_s & ~wr_bank_r);
  assign full_s[1] = (full_r[1] & ~(release_s &  rd_bank_r)) | (commit_ok_s &  wr_bank_r);

  // Read FSM next-state and next read address.
  always_comb begin
    state_s   = state_r;
    k_idx_s   = K_ZERO;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.rd_req && full_r[rd_bank_r]) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_elem_s) begin
          state_s = ST_DRAIN;
          k_idx_s = k_idx_r;
        end else begin
          state_s = ST_STREAM;
          k_idx_s = k_idx_r + K_ONE;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        state_s   = ST_IDLE;
        release_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Read FSM state, read address and read-side outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_idx_r     <= K_ZERO;
      av_pipe_r   <= 2'b00;
      buf_rd_en_r <= 1'b0;
      rd_busy_r   <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      k_idx_r     <= k_idx_s;
      av_pipe_r   <= {av_pipe_r[0], (state_r == ST_STREAM)};
      buf_rd_en_r <= (state_s == ST_STREAM) || (state_s == ST_DRAIN);
      rd_busy_r   <= (state_s != ST_IDLE);
      tile_done_r <= (state_s == ST_DONE);
    end
  end

  // Bank ownership: full flags, tile lengths, fill/drain pointers and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r        <= 2'b00;
      len0_r        <= LEN_ZERO;
      len1_r        <= LEN_ZERO;
      wr_bank_r     <= 1'b0;
      rd_bank_r     <= 1'b0;
      wr_overflow_r <= 1'b0;
      commit_err_r  <= 1'b0;
    end else begin
      full_r        <= full_s;
      wr_overflow_r <= bus.host_we & full_r[wr_bank_r];
      commit_err_r  <= bus.host_commit & ~commit_ok_s;
      if (commit_ok_s) begin
        if (wr_bank_r) begin
          len1_r <= bus.k_len;
        end else begin
          len0_r <= bus.k_len;
        end
        wr_bank_r <= ~wr_bank_r;
      end
      if (release_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
    end
  end

  assign bus.host_wr_ready = ~full_r[wr_bank_r];
  assign bus.buf_we        = bus.host_we & ~full_r[wr_bank_r];
  assign bus.buf_waddr     = bus.host_waddr;
  assign bus.bank_sel_wr   = wr_bank_r;
  assign bus.bank_sel_rd   = rd_bank_r;
  assign bus.bank_full     = full_r;
  assign bus.buf_rd_en     = buf_rd_en_r;
  assign bus.k_idx         = k_idx_r;
  assign bus.rd_busy       = rd_busy_r;
  assign bus.a_valid       = av_pipe_r[1];
  assign bus.tile_done     = tile_done_r;
  assign bus.wr_overflow   = wr_overflow_r;
  assign bus.commit_err    = commit_err_r;

endmodule

// File: tb/tb_act_buffer_ctrl.sv
// Self-checking bench for act_buffer_ctrl: directed scenarios plus random traffic,
// compared every cycle against a tile-offset model of the ping/pong sequencer.
module tb_act_buffer_ctrl;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  act_buffer_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  act_buffer_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: bank flags/lengths, pointers, and the current tile as a cycle offset
  // from its first STREAM cycle (offset L is the drain cycle, L+1 is done).
  bit m_full [2];
  int m_len  [2];
  bit m_wb, m_rb, m_act, m_ovf, m_cerr;
  int m_off;

  bit cur_we, cur_cm, cur_rq;
  int cur_wa, cur_kl;

  int kq[$];
  int av_cnt, td_cnt, td_with_av;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_len[0] = 0; m_len[1] = 0;
    m_wb = 1'b0; m_rb = 1'b0; m_act = 1'b0; m_off = 0;
    m_ovf = 1'b0; m_cerr = 1'b0;
  endtask

  task automatic compare_all();
    int  L;
    int  k;
    bit  rden;
    L    = m_len[m_rb];
    rden = m_act && (m_off <= L);
    if (m_act && m_off < L)       k = m_off;
    else if (m_act && m_off == L) k = L - 1;
    else                          k = 0;
    chk("host_wr_ready", bus.host_wr_ready, {31'd0, !m_full[m_wb]});
    chk("buf_we",        bus.buf_we,        {31'd0, cur_we && !m_full[m_wb]});
    chk("buf_waddr",     bus.buf_waddr,     cur_wa);
    chk("bank_sel_wr",   bus.bank_sel_wr,   {31'd0, m_wb});
    chk("bank_sel_rd",   bus.bank_sel_rd,   {31'd0, m_rb});
    chk("bank_full",     bus.bank_full,     {30'd0, m_full[1], m_full[0]});
    chk("buf_rd_en",     bus.buf_rd_en,     {31'd0, rden});
    chk("k_idx",         bus.k_idx,         k);
    chk("rd_busy",       bus.rd_busy,       {31'd0, m_act});
    chk("a_valid",       bus.a_valid,       {31'd0, m_act && m_off >= 2 && m_off <= L + 1});
    chk("tile_done",     bus.tile_done,     {31'd0, m_act && m_off == L + 1});
    chk("wr_overflow",   bus.wr_overflow,   {31'd0, m_ovf});
    chk("commit_err",    bus.commit_err,    {31'd0, m_cerr});
  endtask

  task automatic model_update();
    bit f0 [2];
    bit wbp, acc;
    f0[0] = m_full[0]; f0[1] = m_full[1];
    wbp   = m_wb;
    acc   = cur_cm && !f0[wbp] && cur_kl >= 1 && cur_kl <= DEPTH;
    m_ovf  = cur_we && f0[wbp];
    m_cerr = cur_cm && !acc;
    if (m_act) begin
      if (m_off == m_len[m_rb] + 1) begin
        m_full[m_rb] = 1'b0;
        m_rb  = !m_rb;
        m_act = 1'b0;
      end else begin
        m_off++;
      end
    end else if (cur_rq && f0[m_rb]) begin
      m_act = 1'b1;
      m_off = 0;
    end
    if (acc) begin
      m_full[wbp] = 1'b1;
      m_len[wbp]  = cur_kl;
      m_wb        = !m_wb;
    end
  endtask

  task automatic drive(input bit we, input int wa, input bit cm, input int kl, input bit rq);
    @(negedge clk);
    cur_we = we; cur_wa = wa; cur_cm = cm; cur_kl = kl; cur_rq = rq;
    bus.host_we     = we;
    bus.host_waddr  = wa[AW-1:0];
    bus.host_commit = cm;
    bus.k_len       = kl[AW:0];
    bus.rd_req      = rq;
    #1;
    compare_all();
    if (bus.buf_rd_en) kq.push_back(int'(bus.k_idx));
    if (bus.a_valid) av_cnt++;
    if (bus.tile_done) begin
      td_cnt++;
      if (bus.a_valid) td_with_av++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit we, input int wa, input bit cm, input int kl, input bit rq);
    drive(we, wa, cm, kl, rq);
    tick();
  endtask

  task automatic clear_obs();
    kq.delete();
    av_cnt = 0; td_cnt = 0; td_with_av = 0;
  endtask

  task automatic apply_reset();
    cur_we = 1'b0; cur_wa = 0; cur_cm = 1'b0; cur_kl = 0; cur_rq = 1'b0;
    bus.host_we = 1'b0; bus.host_waddr = '0; bus.host_commit = 1'b0;
    bus.k_len = '0; bus.rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst host_wr_ready", bus.host_wr_ready, 32'd1);
    chk("rst bank_full",     bus.bank_full,     32'd0);
    chk("rst k_idx",         bus.k_idx,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_overlap(input int commit_at);
    int bf  [16];
    int td  [16];
    int rde [16];
    apply_reset();
    step(1'b1, 0, 1'b1, 8, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      drive((i >= 3 && i <= 5), i, (i == commit_at), 3, 1'b1);
      bf[i]  = int'(bus.bank_full);
      td[i]  = int'(bus.tile_done);
      rde[i] = int'(bus.buf_rd_en);
      tick();
    end
    chk("ovl bank_full first", bf[1], 32'd1);
    chk("ovl bank_full at done", bf[11], (commit_at < 11) ? 32'd3 : 32'd1);
    chk("ovl tile_done at done", td[11], 32'd1);
    chk("ovl bank_full after done", bf[12], 32'd2);
    chk("ovl rd_en idle gap", rde[12], 32'd0);
    chk("ovl bank1 start", rde[13], 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_obs();
    apply_reset();

    // Single tile of four.
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 4, 1'b0);
    clear_obs();
    repeat (10) step(1'b0, 0, 1'b0, 0, 1'b1);
    chk("single rd_en cycles", kq.size(), 32'd5);
    if (kq.size() == 5) begin
      chk("single k0", kq[0], 32'd0);
      chk("single k1", kq[1], 32'd1);
      chk("single k2", kq[2], 32'd2);
      chk("single k3", kq[3], 32'd3);
      chk("single k4", kq[4], 32'd3);
    end
    chk("single a_valid cycles", av_cnt, 32'd4);
    chk("single tile_done", td_cnt, 32'd1);
    chk("single done with a_valid", td_with_av, 32'd1);
    chk("single bank_sel_rd after", bus.bank_sel_rd, 32'd1);

    // Overflow: both banks full.
    apply_reset();
    step(1'b0, 0, 1'b1, 4, 1'b0);
    step(1'b0, 0, 1'b1, 5, 1'b0);
    drive(1'b1, 9, 1'b0, 0, 1'b0);
    chk("ovf buf_we", bus.buf_we, 32'd0);
    chk("ovf ready", bus.host_wr_ready, 32'd0);
    tick();
    drive(1'b0, 0, 1'b1, 3, 1'b0);
    chk("ovf wr_overflow", bus.wr_overflow, 32'd1);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    chk("ovf commit_err", bus.commit_err, 32'd1);
    chk("ovf bank_full", bus.bank_full, 32'd3);
    tick();

    // Length bounds and a full-depth tile.
    apply_reset();
    step(1'b0, 0, 1'b1, 0, 1'b0);
    drive(1'b0, 0, 1'b1, DEPTH + 1, 1'b0);
    chk("bound len0 err", bus.commit_err, 32'd1);
    chk("bound len0 full", bus.bank_full, 32'd0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    chk("bound lenmax+1 err", bus.commit_err, 32'd1);
    chk("bound lenmax+1 full", bus.bank_full, 32'd0);
    tick();
    step(1'b0, 0, 1'b1, DEPTH, 1'b0);
    clear_obs();
    repeat (DEPTH + 8) step(1'b0, 0, 1'b0, 0, 1'b1);
    chk("bound rd_en cycles", kq.size(), DEPTH + 1);
    if (kq.size() == DEPTH + 1) begin
      chk("bound k first", kq[0], 32'd0);
      chk("bound k last", kq[DEPTH - 1], DEPTH - 1);
      chk("bound k drain", kq[DEPTH], DEPTH - 1);
    end
    chk("bound a_valid cycles", av_cnt, DEPTH);

    // Overlapped fill during a stream, then release and commit in the same cycle.
    run_overlap(5);
    run_overlap(11);
    drive(1'b1, 5, 1'b0, 0, 1'b0);
    chk("simul write bank0 accepted", bus.buf_we, 32'd1);
    chk("simul write bank sel", bus.bank_sel_wr, 32'd0);
    tick();

    // Reset in the middle of a stream.
    apply_reset();
    step(1'b0, 0, 1'b1, 8, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b0, 0, 1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("midrst k_idx before", bus.k_idx, 32'd2);
    apply_reset();
    chk("midrst rd_busy", bus.rd_busy, 32'd0);
    chk("midrst a_valid", bus.a_valid, 32'd0);
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    chk("midrst bank_full after", bus.bank_full, 32'd0);
    chk("midrst ready after", bus.host_wr_ready, 32'd1);
    tick();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      int r;
      int kl;
      r = int'($urandom_range(0, 15));
      if (r == 0)      kl = 0;
      else if (r == 1) kl = DEPTH + 1;
      else if (r == 2) kl = DEPTH;
      else             kl = int'($urandom_range(1, 12));
      if ($urandom_range(0, 999) == 0) apply_reset();
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)),
           $urandom_range(0, 5) == 0, kl, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
